bkm_exp_seq: RTL and testbench



---
 rtl/bkm_exp_seq_pkg.sv | 37 +++
 rtl/bkm_exp_seq_if.sv | 22 ++
 rtl/bkm_ln_rom.sv | 24 ++
 rtl/div_by_2_n.sv | 11 +
 rtl/bkm_exp_seq.sv | 119 +++++++++++
 tb/tb_bkm_exp_seq.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bkm_exp_seq_pkg.sv
// rtl/bkm_exp_seq_pkg.sv - shared FSM encoding and ln(1+2^-k) table generator for the BKM exp unit
package bkm_exp_seq_pkg;

   typedef enum logic [1:0] {
      BKM_EXP_IDLE = 2'd0,
      BKM_EXP_RUN  = 2'd1,
      BKM_EXP_DONE = 2'd2
   } bkm_state_e;

   localparam int LN_GUARD = 64;

   // ln(1+y) = 2*atanh(z) with z = 1/(2^(k+1)+1); every series term is a pure division
   function automatic logic [31:0] bkm_ln_const(input int k, input int frac);
      logic [127:0] d;
      logic [127:0] p;
      logic [127:0] acc;
      d   = (128'd1 << (k + 1)) + 128'd1;
      p   = (128'd1 << LN_GUARD) / d;
      acc = '0;
      for (int i = 0; i < LN_GUARD; i++) begin
         acc = acc + p / 128'(2 * i + 1);
         p   = p / (d * d);
      end
      acc = (acc << 1) + (128'd1 << (LN_GUARD - frac - 1));
      return 32'(acc >> (LN_GUARD - frac));
   endfunction

   function automatic logic [31:0] bkm_ln_sum(input int n_iter, input int frac);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < n_iter; k++) begin
         s = s + bkm_ln_const(k, frac);
      end
      return s;
   endfunction

endpackage

// File: rtl/bkm_exp_seq_if.sv
// rtl/bkm_exp_seq_if.sv - argument/result handshake bundle of the BKM exp unit
interface bkm_exp_seq_if #(
   parameter int W = 21
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         range_err;

   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, range_err
   );

   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, range_err
   );
endinterface

// File: rtl/bkm_ln_rom.sv
// rtl/bkm_ln_rom.sv - combinational k -> round(ln(1+2^-k) * 2^FRAC), zero beyond N_ITER-1
module bkm_ln_rom
   import bkm_exp_seq_pkg::*;
#(
   parameter int W      = 21,
   parameter int FRAC   = 16,
   parameter int N_ITER = 17,
   parameter int LOG2N  = 6
) (
   input  logic [LOG2N-1:0] k,
   output logic [W-1:0]     l_k
);
   logic [W-1:0] tbl [2**LOG2N];

   for (genvar g = 0; g < 2**LOG2N; g++) begin : g_tbl
      if (g < N_ITER) begin : g_ent
         assign tbl[g] = W'(bkm_ln_const(g, FRAC));
      end else begin : g_zero
         assign tbl[g] = '0;
      end
   end

   assign l_k = tbl[k];
endmodule

// File: rtl/div_by_2_n.sv
// rtl/div_by_2_n.sv - arithmetic right shift scaler, out = in * 2^-n (truncating)
module div_by_2_n #(
   parameter int W     = 21,
   parameter int LOG2W = 5
) (
   input  logic [LOG2W-1:0] n,
   input  logic [W-1:0]     in,
   output logic [W-1:0]     out
);
   assign out = $signed(in) >>> n;
endmodule

// File: rtl/bkm_exp_seq.sv
// rtl/bkm_exp_seq.sv - sequential BKM E-mode exp(l), one shift-and-add iteration per clock
module bkm_exp_seq
   import bkm_exp_seq_pkg::*;
#(
   parameter int W      = 21,
   parameter int FRAC   = 16,
   parameter int LOG2W  = 5,
   parameter int LOG2N  = 6,
   parameter int N_ITER = 17
) (
   input  logic         clk,
   input  logic         arst,
   bkm_exp_seq_if.slave bus,
   output logic         busy
);
   localparam logic [W-1:0]     ONE    = W'(1) << FRAC;
   localparam logic [W-1:0]     LMAX   = W'(bkm_ln_sum(N_ITER, FRAC));
   localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N_ITER - 1);

   bkm_state_e       state_q, state_d;
   logic [W-1:0]     x_q, x_d;
   logic [W-1:0]     l_q, l_d;
   logic [LOG2N-1:0] k_q, k_d;
   logic             err_q, err_d;

   logic [W-1:0]     l_k;
   logic [W-1:0]     x_shift;
   logic [W-1:0]     t;
   logic             take;
   logic             in_range;

   bkm_ln_rom #(
      .W      (W),
      .FRAC   (FRAC),
      .N_ITER (N_ITER),
      .LOG2N  (LOG2N)
   ) u_rom (
      .k   (k_q),
      .l_k (l_k)
   );

   div_by_2_n #(
      .W     (W),
      .LOG2W (LOG2W)
   ) u_scale (
      .n   (k_q[LOG2W-1:0]),
      .in  (x_q),
      .out (x_shift)
   );

   assign t        = l_q - l_k;
   assign take     = ~t[W-1];
   assign in_range = ~bus.in[W-1] && (bus.in <= LMAX);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= BKM_EXP_IDLE;
         x_q     <= '0;
         l_q     <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         l_q     <= l_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BKM_EXP_IDLE: if (bus.in_valid) state_d = in_range ? BKM_EXP_RUN : BKM_EXP_DONE;
         BKM_EXP_RUN:  if (k_q == K_LAST) state_d = BKM_EXP_DONE;
         BKM_EXP_DONE: if (bus.out_ready) state_d = BKM_EXP_IDLE;
         default:      state_d = BKM_EXP_IDLE;
      endcase
   end

   // Out-of-domain arguments skip RUN and report a zero result with range_err set
   always_comb begin
      x_d   = x_q;
      l_d   = l_q;
      k_d   = k_q;
      err_d = err_q;
      case (state_q)
         BKM_EXP_IDLE: begin
            if (bus.in_valid) begin
               if (in_range) begin
                  x_d   = ONE;
                  l_d   = bus.in;
                  k_d   = '0;
                  err_d = 1'b0;
               end else begin
                  x_d   = '0;
                  err_d = 1'b1;
               end
            end
         end
         BKM_EXP_RUN: begin
            if (take) begin
               l_d = t;
               x_d = x_q + x_shift;
            end
            k_d = k_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == BKM_EXP_IDLE);
      bus.out_valid = (state_q == BKM_EXP_DONE);
      busy          = (state_q == BKM_EXP_RUN);
      bus.out       = x_q;
      bus.range_err = err_q;
   end
endmodule

// File: tb/tb_bkm_exp_seq.sv
// tb/tb_bkm_exp_seq.sv - directed and swept checks of bkm_exp_seq against an exp model
module tb_bkm_exp_seq;
   localparam int W      = 21;
   localparam int FRAC   = 16;
   localparam int LOG2W  = 5;
   localparam int LOG2N  = 6;
   localparam int N_ITER = 17;
   localparam int TOL    = N_ITER + 2;

   logic clk = 1'b0;
   logic arst;
   logic busy;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ltab [N_ITER];
   int   lmax;

   bkm_exp_seq_if #(.W(W)) bus ();

   bkm_exp_seq #(
      .W      (W),
      .FRAC   (FRAC),
      .LOG2W  (LOG2W),
      .LOG2N  (LOG2N),
      .N_ITER (N_ITER)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic chk_tol(input string name, input int act, input real req, input int tol);
      real d;
      checks++;
      d = real'(act) - req;
      if (d < 0.0) d = -d;
      if (d > real'(tol)) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want %f +/- %0d", name, act, req, tol);
      end
   endtask

   function automatic void init_model();
      real p;
      p    = 1.0;
      lmax = 0;
      for (int k = 0; k < N_ITER; k++) begin
         ltab[k] = $rtoi($ln(1.0 + p) * real'(1 << FRAC) + 0.5);
         lmax   += ltab[k];
         p       = p / 2.0;
      end
   endfunction

   // Greedy decomposition of l into ln(1+2^-k) terms; x picks up the matching (1+2^-k) factors
   function automatic int model_exp(input int v);
      int x;
      int l;
      x = 1 << FRAC;
      l = v;
      for (int k = 0; k < N_ITER; k++) begin
         if (l >= ltab[k]) begin
            l -= ltab[k];
            x += x >>> k;
         end
      end
      return x;
   endfunction

   function automatic int to_signed(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   typedef struct {
      int val;
      int err;
      int acc;
      int arg;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   have_cur = 1'b0;
   bit   prev_ov  = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      int   s;
      if (arst) begin
         q.delete();
         have_cur = 1'b0;
         prev_ov  = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (!prev_ov) begin
               if (q.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
                  have_cur = 1'b0;
               end else begin
                  cur      = q.pop_front();
                  have_cur = 1'b1;
                  chk("latency", cyc - cur.acc + 1, cur.err != 0 ? 1 : N_ITER + 1);
                  if (cur.err == 0)
                     chk_tol("exp_vs_real", int'(bus.out),
                             $exp(real'(cur.arg) / real'(1 << FRAC)) * real'(1 << FRAC), TOL);
               end
            end
            if (have_cur) begin
               chk("out", int'(bus.out), cur.val);
               chk("range_err", int'(bus.range_err), cur.err);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            s     = to_signed(bus.in);
            e.arg = s;
            e.acc = cyc + 1;
            if (s >= 0 && s <= lmax) begin
               e.val = model_exp(s);
               e.err = 0;
            end else begin
               e.val = 0;
               e.err = 1;
            end
            q.push_back(e);
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_wait", int'(bus.out_valid), 1);
   endtask

   task automatic run_one(input logic [W-1:0] v, output int res);
      int n;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", int'(bus.in_ready), 1);
      bus.in       = v;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid();
      res           = int'(bus.out);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  int'(bus.in_ready),  1);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_out"},       int'(bus.out),       0);
      chk({tag, "_range_err"}, int'(bus.range_err), 0);
      chk({tag, "_busy"},      int'(busy),          0);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycle budget of 60000 exhausted");
      $fatal(1);
   end

   initial begin
      int r;
      int acc;
      int prev;
      int n;
      init_model();
      arst          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in        = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");

      chk("model_L0",   ltab[0], 'h0B172);
      chk("model_L1",   ltab[1], 'h067CD);
      chk("model_lmax", lmax,    'h18FE1);
      chk("model_exp0", model_exp(0), 'h10000);
      chk("model_ln2",  model_exp('h0B172), 'h20000);

      arst = 1'b0;
      @(negedge clk);
      run_one(21'h00000, r);
      chk("exp_0", r, 'h10000);
      run_one(21'h0B172, r);
      chk("exp_ln2", r, 'h20000);
      run_one(21'h11940, r);
      chk_tol("exp_ln3", r, real'('h30000), N_ITER);
      run_one(21'h1FFFFF, r);
      chk("neg_out", r, 0);
      run_one(W'(lmax + 1), r);
      chk("over_out", r, 0);
      run_one(W'(lmax), r);
      run_one(21'h00001, r);

      // Back-pressure: result held, no acceptance while DONE
      bus.in       = 21'h0B172;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("bp_out",       int'(bus.out),       'h20000);
         chk("bp_out_valid", int'(bus.out_valid), 1);
         chk("bp_in_ready",  int'(bus.in_ready),  0);
         if (i == 2) begin
            bus.in       = '0;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("bp_release_valid", int'(bus.out_valid), 0);
      chk("bp_release_ready", int'(bus.in_ready),  1);
      chk("bp_release_busy",  int'(busy),          0);

      // Asynchronous abort with k == 8
      bus.in       = 21'h08000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk("pre_abort_busy", int'(busy), 1);
      arst = 1'b1;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk);
      arst = 1'b0;
      run_one(21'h00000, r);
      chk("post_abort_exp0", r, 'h10000);

      // Back-to-back sweep with in_valid and out_ready held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      prev          = 0;
      for (int i = 0; i < 1000; i++) begin
         bus.in = W'($urandom_range(32'(lmax), 0));
         n = 0;
         @(negedge clk);
         while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
         #1;
         acc = cyc;
         if (i > 0) chk("accept_spacing", acc - prev, N_ITER + 2);
         prev = acc;
      end
      bus.in_valid = 1'b0;
      repeat (25) @(negedge clk);
      bus.out_ready = 1'b0;
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
